loop_sequencer: RTL and testbench

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

---
 rtl/loop_sequencer_if.sv | 20 ++
 rtl/loop_sequencer.sv | 131 +++++++++++++
 tb/tb_loop_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_sequencer_if.sv
// ADC request/response handshake and PWM duty update bundle for loop_sequencer.
// master = sequencer side, slave = ADC SPI master / PWM side.
interface loop_sequencer_if;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [9:0]  duty_mag;
  logic        duty_dir;
  logic        duty_valid;

  modport master (
    output adc_start, duty_mag, duty_dir, duty_valid,
    input  adc_done, adc_data
  );

  modport slave (
    input  adc_start, duty_mag, duty_dir, duty_valid,
    output adc_done, adc_data
  );
endinterface

// File: rtl/loop_sequencer.sv
// Periodic proportional control loop: tick -> ADC sample -> P-term -> duty update,
// with ADC timeout and missed-tick (overrun) sticky flags.
module loop_sequencer #(
  parameter int unsigned PERIOD_CYCLES = 1000,
  parameter int unsigned ADC_TIMEOUT   = 255,
  parameter int unsigned KP_SHIFT      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [11:0]            setpoint,
  input  logic                   setpoint_valid,
  input  logic [7:0]             kp,
  input  logic                   clear_faults,
  loop_sequencer_if.master       bus,
  output logic                   fault,
  output logic                   overrun,
  output logic [15:0]            sample_cnt
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ADC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, ADC_REQ, ADC_WAIT, COMPUTE, UPDATE
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   per_cnt;
  logic [TW-1:0]   to_cnt;
  logic [11:0]     sp_reg, snap, sample;
  logic [9:0]      duty_mag;
  logic            duty_dir, duty_valid;
  logic            tick, adc_fire, to_fire;
  logic signed [12:0] err;
  logic signed [20:0] err_x, kp_x, prod, scaled;
  logic [20:0]     absval;
  logic [9:0]      mag_c;

  assign tick     = enable && (per_cnt == PER_LAST);
  assign adc_fire = (state == ADC_WAIT) && bus.adc_done;
  // adc_done beats the timeout when both land on the last wait cycle
  assign to_fire  = (state == ADC_WAIT) && !bus.adc_done && (to_cnt == TO_LAST);

  assign bus.adc_start  = (state == ADC_REQ);
  assign bus.duty_mag   = duty_mag;
  assign bus.duty_dir   = duty_dir;
  assign bus.duty_valid = duty_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                per_cnt <= '0;
    else if (!enable)            per_cnt <= '0;
    else if (per_cnt == PER_LAST) per_cnt <= '0;
    else                         per_cnt <= per_cnt + PW'(1);
  end

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      state_n = WAIT_TICK;
        WAIT_TICK: if (tick) state_n = ADC_REQ;
        ADC_REQ:   state_n = ADC_WAIT;
        ADC_WAIT:  if (bus.adc_done) state_n = COMPUTE;
                   else if (to_fire) state_n = WAIT_TICK;
        COMPUTE:   state_n = UPDATE;
        UPDATE:    state_n = WAIT_TICK;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    err    = $signed({1'b0, snap}) - $signed({1'b0, sample});
    err_x  = 21'(err);
    kp_x   = {13'b0, kp};
    prod   = err_x * kp_x;
    scaled = prod >>> KP_SHIFT;
    absval = scaled[20] ? $unsigned(-scaled) : $unsigned(scaled);
    mag_c  = (absval > 21'd1023) ? 10'd1023 : absval[9:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      sp_reg     <= '0;
      snap       <= '0;
      sample     <= '0;
      duty_mag   <= '0;
      duty_dir   <= 1'b0;
      duty_valid <= 1'b0;
      fault      <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state      <= state_n;
      duty_valid <= 1'b0;
      if (setpoint_valid) sp_reg <= setpoint;
      if (state == ADC_REQ) begin
        snap   <= sp_reg;
        to_cnt <= '0;
      end
      if (state == ADC_WAIT) to_cnt <= to_cnt + TW'(1);
      if (adc_fire) sample <= bus.adc_data;

      // duty registers load at the end of COMPUTE so they read new in UPDATE
      if (enable && state == COMPUTE) begin
        duty_mag   <= mag_c;
        duty_dir   <= scaled[20];
        duty_valid <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
      end else if (enable && to_fire) begin
        duty_mag   <= '0;
        duty_dir   <= 1'b0;
        duty_valid <= 1'b1;
      end

      if (enable && to_fire) fault <= 1'b1;
      else if (clear_faults) fault <= 1'b0;

      if (tick && state != WAIT_TICK) overrun <= 1'b1;
      else if (clear_faults)          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with hand-computed results, then randomized traffic.
module tb_loop_sequencer;

  localparam int P  = 16;
  localparam int TO = 20;
  localparam int KS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] setpoint = '0;
  logic        setpoint_valid = 1'b0;
  logic [7:0]  kp = '0;
  logic        clear_faults = 1'b0;
  logic        fault, overrun;
  logic [15:0] sample_cnt;

  loop_sequencer_if bus();

  loop_sequencer #(.PERIOD_CYCLES(P), .ADC_TIMEOUT(TO), .KP_SHIFT(KS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .setpoint(setpoint),
    .setpoint_valid(setpoint_valid), .kp(kp), .clear_faults(clear_faults),
    .bus(bus), .fault(fault), .overrun(overrun), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic void calc(input int sp, input int smp, input int k,
                               output logic [9:0] mag, output logic dir);
    int prod, d, q, a;
    prod = (sp - smp) * k;
    d = 1 << KS;
    if (prod >= 0) q = prod / d;
    else           q = -((-prod + d - 1) / d);
    dir = (q < 0);
    a = (q < 0) ? -q : q;
    mag = (a > 1023) ? 10'd1023 : 10'(a);
  endfunction

  // ---------------- reference model (sampled on the falling edge) ----------------
  int          mc = 0;
  int          m_cnt = 0, m_t0 = 0, m_M = 0;
  bit          m_busy = 0, m_got = 0;
  logic [11:0] m_sp = '0, m_snap = '0, m_samp = '0;
  logic        e_valid = 0, e_dir = 0, e_fault = 0, e_over = 0;
  logic [9:0]  e_mag = '0;
  logic [15:0] e_scnt = '0;

  always @(negedge clk) begin
    bit e_start, tick, ovr_set, flt_set;
    if (!reset_n) begin
      m_cnt = 0; m_busy = 0; m_got = 0; m_sp = '0; m_snap = '0; m_samp = '0;
      e_valid = 0; e_dir = 0; e_fault = 0; e_over = 0; e_mag = '0; e_scnt = '0;
    end
    e_start = m_busy && (mc == m_t0 + 1);
    vectors++;
    if ({bus.adc_start, bus.duty_valid, bus.duty_dir, bus.duty_mag, fault, overrun, sample_cnt}
        !== {e_start, e_valid, e_dir, e_mag, e_fault, e_over, e_scnt}) begin
      miscompares++;
      $display("FAIL cycle%0d outputs: start %b/%b valid %b/%b dir %b/%b mag %0d/%0d fault %b/%b ovr %b/%b cnt %0d/%0d (actual/expected)",
               mc, bus.adc_start, e_start, bus.duty_valid, e_valid, bus.duty_dir, e_dir,
               bus.duty_mag, e_mag, fault, e_fault, overrun, e_over, sample_cnt, e_scnt);
    end
    if (reset_n) begin
      e_valid = 0;
      ovr_set = 0;
      flt_set = 0;
      if (!enable) begin
        m_busy = 0;
        m_cnt = 0;
      end else begin
        tick = (m_cnt == P - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        ovr_set = tick && m_busy;
        if (m_busy) begin
          if (mc == m_t0 + 1) m_snap = m_sp;
          if (!m_got && mc >= m_t0 + 2 && mc <= m_t0 + 1 + TO) begin
            if (bus.adc_done) begin
              m_got = 1; m_M = mc; m_samp = bus.adc_data;
            end else if (mc == m_t0 + 1 + TO) begin
              flt_set = 1; e_valid = 1; e_mag = '0; e_dir = 0; m_busy = 0;
            end
          end else if (m_got && mc == m_M + 1) begin
            calc(int'(m_snap), int'(m_samp), int'(kp), e_mag, e_dir);
            e_valid = 1;
            e_scnt = e_scnt + 16'd1;
          end else if (m_got && mc == m_M + 2) begin
            m_busy = 0;
          end
        end
        if (tick && !ovr_set) begin
          m_busy = 1; m_got = 0; m_t0 = mc;
        end
      end
      e_fault = flt_set ? 1'b1 : (clear_faults ? 1'b0 : e_fault);
      e_over  = ovr_set ? 1'b1 : (clear_faults ? 1'b0 : e_over);
      if (setpoint_valid) m_sp = setpoint;
    end
    mc++;
  end

  // ---------------- stimulus helpers ----------------
  int          cyc = 0;
  int          pend = 0, resp_lat = 0, start_cyc = 0, valid_cyc = 0;
  logic [11:0] adc_val = '0;
  bit          stray_en = 0;

  // one clock: strobes drop, ADC responder answers resp_lat cycles after adc_start
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    setpoint_valid = 1'b0;
    clear_faults = 1'b0;
    bus.adc_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.adc_done = 1'b1;
        bus.adc_data = adc_val;
      end
    end
    if (stray_en && $urandom_range(0, 49) == 0) begin
      bus.adc_done = 1'b1;
      bus.adc_data = 12'($urandom_range(0, 4095));
    end
    if (bus.adc_start && resp_lat > 0) pend = resp_lat;
  endtask

  task automatic wait_start(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (bus.adc_start) begin ok = 1; start_cyc = cyc; end
    end
    chk({tag, "_start_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (bus.duty_valid) begin ok = 1; valid_cyc = cyc; end
    end
    chk({tag, "_valid_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic loop_once(input string tag, input int sp, input int k, input int av,
                           input int lat, input int emag, input int edir);
    setpoint = 12'(sp); setpoint_valid = 1'b1; kp = 8'(k); adc_val = 12'(av); resp_lat = lat;
    wait_start(tag, 3 * P);
    wait_valid(tag, TO + 4);
    chk({tag, "_mag"}, 32'(bus.duty_mag), 32'(emag));
    chk({tag, "_dir"}, 32'(bus.duty_dir), 32'(edir));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, en_cyc, rcyc, nval, nstart;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    repeat (3) step();
    chk("rst_mag", 32'(bus.duty_mag), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_flags", 32'({fault, overrun, bus.adc_start, bus.duty_valid}), 32'd0);
    reset_n = 1'b1;
    step();

    // setpoint 1000, ADC 900 after 5 cycles, kp 16 -> duty 100 forward
    setpoint = 12'd1000; setpoint_valid = 1'b1; kp = 8'd16; adc_val = 12'd900; resp_lat = 5;
    enable = 1'b1;
    en_cyc = cyc;
    wait_start("basic", 3 * P);
    chk("basic_tick_to_start", 32'(start_cyc - en_cyc), 32'(P));
    wait_valid("basic", TO + 4);
    chk("basic_done_to_valid", 32'(valid_cyc - start_cyc), 32'd7);
    chk("basic_mag", 32'(bus.duty_mag), 32'd100);
    chk("basic_dir", 32'(bus.duty_dir), 32'd0);
    chk("basic_cnt", 32'(sample_cnt), 32'd1);

    loop_once("neg800", 100, 32, 500, 3, 800, 1);
    loop_once("sat",    4095, 255, 0, 2, 1023, 0);
    loop_once("floor",  17, 1, 18, 6, 1, 1);

    // ADC silent: timeout fault, zero duty, no count
    resp_lat = 0;
    wait_start("to1", 3 * P);
    s0 = start_cyc;
    wait_valid("to1", TO + 4);
    chk("to1_latency", 32'(valid_cyc - s0), 32'(TO + 1));
    chk("to1_fault", 32'(fault), 32'd1);
    chk("to1_mag", 32'(bus.duty_mag), 32'd0);
    chk("to1_dir", 32'(bus.duty_dir), 32'd0);
    chk("to1_cnt", 32'(sample_cnt), 32'd4);
    chk("to1_overrun", 32'(overrun), 32'd1);
    clear_faults = 1'b1;
    step();
    chk("clear_fault", 32'(fault), 32'd0);
    chk("clear_overrun", 32'(overrun), 32'd0);

    // clear coincident with the second timeout: set wins
    wait_start("to2", 3 * P);
    repeat (TO) step();
    clear_faults = 1'b1;
    step();
    chk("to2_valid", 32'(bus.duty_valid), 32'd1);
    chk("to2_fault_kept", 32'(fault), 32'd1);
    clear_faults = 1'b1;
    step();

    // ADC latency beyond the period: overrun, tick skipped
    setpoint = 12'd1000; setpoint_valid = 1'b1; kp = 8'd16; adc_val = 12'd900; resp_lat = 18;
    wait_start("ovr", 3 * P);
    s0 = start_cyc;
    wait_valid("ovr", TO + 4);
    chk("ovr_latency", 32'(valid_cyc - s0), 32'd20);
    chk("ovr_mag", 32'(bus.duty_mag), 32'd100);
    chk("ovr_flag", 32'(overrun), 32'd1);
    resp_lat = 5;
    wait_start("ovr_next", 3 * P);
    chk("ovr_next_start", 32'(start_cyc - s0), 32'(2 * P));
    wait_valid("ovr_next", TO + 4);

    // setpoint change while waiting for the ADC applies only to the next loop
    resp_lat = 10;
    wait_start("spin", 3 * P);
    repeat (3) step();
    setpoint = 12'd1200; setpoint_valid = 1'b1;
    wait_valid("spin", TO + 4);
    chk("spin_old_mag", 32'(bus.duty_mag), 32'd100);
    wait_start("spnew", 3 * P);
    wait_valid("spnew", TO + 4);
    chk("spnew_mag", 32'(bus.duty_mag), 32'd300);

    // enable dropped during ADC_WAIT: late adc_done ignored
    resp_lat = 8;
    wait_start("dis", 3 * P);
    repeat (3) step();
    enable = 1'b0;
    nval = 0; nstart = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      nval += int'(bus.duty_valid);
      nstart += int'(bus.adc_start);
    end
    chk("dis_no_valid", 32'(nval), 32'd0);
    chk("dis_no_start", 32'(nstart), 32'd0);
    chk("dis_mag_held", 32'(bus.duty_mag), 32'd300);
    enable = 1'b1;

    // reset pulsed during COMPUTE
    resp_lat = 4;
    wait_start("rst", 3 * P);
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mag", 32'(bus.duty_mag), 32'd0);
    chk("rst_mid_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_mid_flags", 32'({fault, overrun, bus.adc_start, bus.duty_valid, bus.duty_dir}), 32'd0);
    step();
    reset_n = 1'b1;
    rcyc = cyc;
    wait_start("post_rst", 3 * P);
    chk("post_rst_start", 32'(start_cyc - rcyc), 32'(P));

    // randomized traffic
    stray_en = 1;
    begin
      int dis;
      dis = 0;
      for (int i = 0; i < 5000; i++) begin
        step();
        if (!reset_n) reset_n = 1'b1;
        else if ($urandom_range(0, 2999) == 0) reset_n = 1'b0;
        if (dis > 0) begin
          dis--;
          if (dis == 0) enable = 1'b1;
        end else if ($urandom_range(0, 399) == 0) begin
          enable = 1'b0;
          dis = int'($urandom_range(1, 6));
        end
        if ($urandom_range(0, 7) == 0) begin
          setpoint_valid = 1'b1;
          setpoint = 12'($urandom_range(0, 4095));
        end
        if ($urandom_range(0, 99) == 0) kp = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 59) == 0) clear_faults = 1'b1;
        adc_val = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 19))
          0:       resp_lat = 0;
          1, 2, 3: resp_lat = int'($urandom_range(13, 22));
          default: resp_lat = int'($urandom_range(1, 12));
        endcase
      end
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
